// File: rtl/an_ordered_set_sender.sv
// an_ordered_set_sender
// ---------------------------------------------------------------------------
// SGMII link-partner model. It drives an 8b/10b serial stream toward the
// receive pins of the device under test. With no request pending it sends
// /I/ ordered sets. A rising edge on start begins auto-negotiation:
// REPEAT x (/C1/,/C2/) carrying the captured config word, then REPEAT x
// (/C1/,/C2/) with the ACK bit (bit 14) forced high. After that, done goes
// high and the model returns to idle.
//
// Ports
//   ser_sgmii_clk  in   serial bit clock, one line bit per rising edge
//   reset          in   synchronous active-high reset
//   start          in   a 0->1 transition requests an auto-negotiation run
//   an_config      in   16-bit config word, captured when the run begins
//   done           out  high once the run has completed
//   an_sgmii_rx_p  out  serial data, true polarity
//   an_sgmii_rx_n  out  complement of an_sgmii_rx_p
//   sgmii_clk_out  out  word clock (bit clock / 10), rises on the first bit
//                       of every code-group
// ---------------------------------------------------------------------------
module an_ordered_set_sender #(
  parameter int REPEAT = 4
) (
  input  logic        ser_sgmii_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] an_config,
  output logic        done,
  output logic        an_sgmii_rx_p,
  output logic        an_sgmii_rx_n,
  output logic        sgmii_clk_out
);

  typedef enum logic [1:0] {IDLE, CFG, CFG_ACK, DONE} state_t;

  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] D21_5    = 8'hB5;
  localparam logic [7:0] D2_2     = 8'h42;
  localparam logic [7:0] D16_2    = 8'h50;
  localparam logic [7:0] D5_6     = 8'hC5;
  localparam logic [7:0] REP_LAST = 8'(REPEAT - 1);

  // 8b/10b encoder. Returns {rd_out, a,b,c,d,e,i,f,g,h,j}; rd = 1 means
  // positive running disparity. The only control character this block ever
  // sends is K28.5, so k selects K28.5 regardless of d.
  function automatic logic [10:0] enc8b10b(input logic [7:0] d, input logic k,
                                           input logic rd);
    logic [5:0] six;
    logic [3:0] four;
    logic       rd_mid;
    logic       rd_out;
    logic       alt7;
    six    = 6'b0;
    four   = 4'b0;
    rd_mid = rd;
    rd_out = rd;
    alt7   = 1'b0;
    if (k) begin
      six    = rd ? 6'b110000 : 6'b001111;
      four   = rd ? 4'b0101 : 4'b1010;
      rd_out = ~rd;
    end else begin
      // 5b/6b, RD- column
      case (d[4:0])
        5'd0:  six = 6'b100111;  5'd1:  six = 6'b011101;
        5'd2:  six = 6'b101101;  5'd3:  six = 6'b110001;
        5'd4:  six = 6'b110101;  5'd5:  six = 6'b101001;
        5'd6:  six = 6'b011001;  5'd7:  six = 6'b111000;
        5'd8:  six = 6'b111001;  5'd9:  six = 6'b100101;
        5'd10: six = 6'b010101;  5'd11: six = 6'b110100;
        5'd12: six = 6'b001101;  5'd13: six = 6'b101100;
        5'd14: six = 6'b011100;  5'd15: six = 6'b010111;
        5'd16: six = 6'b011011;  5'd17: six = 6'b100011;
        5'd18: six = 6'b010011;  5'd19: six = 6'b110010;
        5'd20: six = 6'b001011;  5'd21: six = 6'b101010;
        5'd22: six = 6'b011010;  5'd23: six = 6'b111010;
        5'd24: six = 6'b110011;  5'd25: six = 6'b100110;
        5'd26: six = 6'b010110;  5'd27: six = 6'b110110;
        5'd28: six = 6'b001110;  5'd29: six = 6'b101110;
        5'd30: six = 6'b011110;  5'd31: six = 6'b101011;
      endcase
      // RD+ column: unbalanced codes are complemented; D.7 is the one
      // balanced code with a disparity-dependent alternate.
      if (rd) begin
        if (d[4:0] == 5'd7)
          six = 6'b000111;
        else if ($countones(six) != 3)
          six = ~six;
      end
      rd_mid = rd ^ ($countones(six) != 3);
      // D.x.A7 avoids a run of five identical bits across the sub-blocks.
      alt7 = (!rd_mid && (d[4:0] == 5'd17 || d[4:0] == 5'd18 || d[4:0] == 5'd20)) ||
             ( rd_mid && (d[4:0] == 5'd11 || d[4:0] == 5'd13 || d[4:0] == 5'd14));
      case (d[7:5])
        3'd0: four = rd_mid ? 4'b0100 : 4'b1011;
        3'd1: four = 4'b1001;
        3'd2: four = 4'b0101;
        3'd3: four = rd_mid ? 4'b0011 : 4'b1100;
        3'd4: four = rd_mid ? 4'b0010 : 4'b1101;
        3'd5: four = 4'b1010;
        3'd6: four = 4'b0110;
        3'd7: four = alt7 ? (rd_mid ? 4'b1000 : 4'b0111)
                          : (rd_mid ? 4'b0001 : 4'b1110);
      endcase
      rd_out = rd_mid ^ ($countones(four) != 2);
    end
    return {rd_out, six, four};
  endfunction

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg;
  logic [1:0]  word_cnt_reg;
  logic [7:0]  rep_cnt_reg;
  logic        half_reg;       // 0: sending /C1/, 1: sending /C2/
  logic        rd_reg;         // running disparity, 1 = positive
  logic [8:0]  shift_reg;      // remaining bits of the current code-group
  logic        rx_reg;
  logic        clk_out_reg;
  logic        done_reg;
  logic        start_d_reg;
  logic        pending_reg;
  logic [15:0] cfg_reg;

  logic        start_edge;
  logic        idle_like;
  logic        last_word;
  logic        set_end;
  logic        last_pair;
  logic        go;
  logic        done_next;
  logic [7:0]  sym_byte;
  logic        sym_k;
  logic [10:0] enc;

  assign start_edge = start & ~start_d_reg;
  assign idle_like  = (state_reg == IDLE) || (state_reg == DONE);
  assign last_word  = idle_like ? (word_cnt_reg == 2'd1) : (word_cnt_reg == 2'd3);
  assign set_end    = (bit_cnt_reg == 4'd9) && last_word;
  assign last_pair  = half_reg && (rep_cnt_reg == REP_LAST);
  assign go         = pending_reg | start_edge;

  // State register
  always_ff @(posedge ser_sgmii_clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next state: changes only on the last bit of an ordered set
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (set_end && go)        state_next = CFG;
      CFG:     if (set_end && last_pair) state_next = CFG_ACK;
      CFG_ACK: if (set_end && last_pair) state_next = DONE;
      DONE:    if (set_end && go)        state_next = CFG;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: code-group selection and done
  always_comb begin
    done_next = (state_reg == DONE);
    sym_k     = 1'b0;
    sym_byte  = K28_5;
    case (word_cnt_reg)
      2'd0: sym_k = 1'b1;
      // In idle, rd_reg here already reflects the K28.5 just sent, so a
      // positive value means the set started negative: /I2/ (D16.2).
      2'd1: sym_byte = idle_like ? (rd_reg ? D16_2 : D5_6)
                                 : (half_reg ? D2_2 : D21_5);
      2'd2: sym_byte = cfg_reg[7:0];
      2'd3: sym_byte = {cfg_reg[15], cfg_reg[14] | (state_reg == CFG_ACK),
                        cfg_reg[13:8]};
    endcase
  end

  assign enc = enc8b10b(sym_byte, sym_k, rd_reg);

  // Serializer, counters and request handling
  always_ff @(posedge ser_sgmii_clk) begin
    if (reset) begin
      bit_cnt_reg  <= 4'd0;
      word_cnt_reg <= 2'd0;
      rep_cnt_reg  <= 8'd0;
      half_reg     <= 1'b0;
      rd_reg       <= 1'b0;
      shift_reg    <= 9'd0;
      rx_reg       <= 1'b0;
      clk_out_reg  <= 1'b0;
      done_reg     <= 1'b0;
      start_d_reg  <= 1'b0;
      pending_reg  <= 1'b0;
      cfg_reg      <= 16'd0;
    end else begin
      start_d_reg <= start;
      done_reg    <= done_next;
      clk_out_reg <= (bit_cnt_reg < 4'd5);

      if (bit_cnt_reg == 4'd0) begin
        rx_reg    <= enc[9];
        shift_reg <= enc[8:0];
        rd_reg    <= enc[10];
      end else begin
        rx_reg    <= shift_reg[8];
        shift_reg <= {shift_reg[7:0], 1'b0};
      end

      bit_cnt_reg <= (bit_cnt_reg == 4'd9) ? 4'd0 : bit_cnt_reg + 4'd1;
      if (bit_cnt_reg == 4'd9)
        word_cnt_reg <= last_word ? 2'd0 : word_cnt_reg + 2'd1;

      // A request is only remembered while idle; edges during a run are dropped.
      if (set_end && idle_like && go)
        pending_reg <= 1'b0;
      else if (start_edge && idle_like)
        pending_reg <= 1'b1;

      if (set_end && idle_like && go)
        cfg_reg <= an_config;

      if (set_end) begin
        if (idle_like) begin
          rep_cnt_reg <= 8'd0;
          half_reg    <= 1'b0;
        end else if (half_reg) begin
          half_reg    <= 1'b0;
          rep_cnt_reg <= last_pair ? 8'd0 : rep_cnt_reg + 8'd1;
        end else begin
          half_reg <= 1'b1;
        end
      end
    end
  end

  assign an_sgmii_rx_p = rx_reg;
  assign an_sgmii_rx_n = ~rx_reg;
  assign sgmii_clk_out = clk_out_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_an_ordered_set_sender.sv
// tb_an_ordered_set_sender
// ---------------------------------------------------------------------------
// Directed bench for an_ordered_set_sender. A monitor deserialises the line
// using the word clock, decodes each code-group against a table of full
// 10-bit codes with running-disparity tracking, reassembles ordered sets and
// checks /C/ sets against a scoreboard queue filled when start is driven.
// ---------------------------------------------------------------------------
module tb_an_ordered_set_sender;

  localparam int R       = 4;
  localparam int SEQ_LEN = 2 * R * 2 * 40;   // bit-clocks, first /C1/ bit to done

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] an_config;
  logic        done;
  logic        rx_p;
  logic        rx_n;
  logic        clk_out;

  an_ordered_set_sender #(.REPEAT(R)) dut (
    .ser_sgmii_clk (clk),
    .reset         (reset),
    .start         (start),
    .an_config     (an_config),
    .done          (done),
    .an_sgmii_rx_p (rx_p),
    .an_sgmii_rx_n (rx_n),
    .sgmii_clk_out (clk_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [8:0] ch;
    logic [7:0] lo;
    logic [7:0] hi;
    bit         first;
  } cset_t;
  cset_t exp_q[$];

  // Full code-groups for every character the stream may legally contain
  // (ch = {K, byte}); rdp selects the RD+ column.
  function automatic logic [9:0] ref_code(input logic [8:0] ch, input bit rdp);
    case (ch)
      9'h1BC:  return rdp ? 10'b1100000101 : 10'b0011111010;  // K28.5
      9'h050:  return rdp ? 10'b1001000101 : 10'b0110110101;  // D16.2
      9'h0C5:  return 10'b1010010110;                         // D5.6
      9'h0B5:  return 10'b1010101010;                         // D21.5
      9'h042:  return rdp ? 10'b0100100101 : 10'b1011010101;  // D2.2
      9'h0E0:  return rdp ? 10'b0110001110 : 10'b1001110001;  // D0.7
      9'h001:  return rdp ? 10'b1000101011 : 10'b0111010100;  // D1.0
      9'h041:  return rdp ? 10'b1000100101 : 10'b0111010101;  // D1.2
      default: return 10'b0;
    endcase
  endfunction

  logic [8:0] chars [8] = '{9'h1BC, 9'h050, 9'h0C5, 9'h0B5, 9'h042, 9'h0E0, 9'h001, 9'h041};

  // monitor state
  bit         prev_clk = 0;
  bit         in_word = 0;
  int         nbits = 0;
  int         last_rise = -1;
  int         high_start = -1;
  int         wstart = 0;
  logic [9:0] wsh;
  logic [9:0] wlog [4];
  int         nw = 0;
  bit         rd_m = 0;
  int         set_pos = 0;
  bit         set_rd0 = 0;
  int         set_start = 0;
  logic [8:0] set_ch;
  logic [7:0] set_lo;
  int         t0 = -1;
  int         idle_sets = 0;

  task automatic handle_word(input logic [9:0] w);
    bit         found = 0;
    logic [8:0] ch = 9'h0;
    bit         rd_before;
    cset_t      e;
    if (nw < 4) wlog[nw] = w;
    nw++;
    for (int i = 0; i < 8; i++)
      if (ref_code(chars[i], rd_m) == w) begin
        found = 1;
        ch = chars[i];
      end
    chk("code_valid", 32'(found), 32'd1);
    rd_before = rd_m;
    if (!found) begin
      set_pos = 0;
    end else begin
      rd_m = rd_m ^ ($countones(w) != 5);
      if (ch == 9'h1BC) begin
        if (set_pos != 0) chk("set_cut", set_pos, 0);
        set_pos   = 1;
        set_rd0   = rd_before;
        set_start = wstart;
      end else if (set_pos == 0) begin
        chk("stray_char", 32'(ch), 32'h1BC);
      end else if (set_pos == 1) begin
        if (ch == 9'h050 || ch == 9'h0C5) begin
          chk("idle_kind", 32'(ch), set_rd0 ? 32'h0C5 : 32'h050);
          idle_sets++;
          set_pos = 0;
        end else begin
          chk("c_char", 32'(ch == 9'h0B5 || ch == 9'h042), 32'd1);
          set_ch  = ch;
          set_pos = 2;
        end
      end else if (set_pos == 2) begin
        set_lo  = ch[7:0];
        set_pos = 3;
      end else begin
        set_pos = 0;
        chk("cfg_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("c_type", 32'(set_ch), 32'(e.ch));
          chk("c_lo", 32'(set_lo), 32'(e.lo));
          chk("c_hi", 32'(ch[7:0]), 32'(e.hi));
          if (e.first) t0 = set_start;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      prev_clk = 0; in_word = 0; nbits = 0; nw = 0; rd_m = 0; set_pos = 0;
      last_rise = -1; high_start = -1;
    end else if (reset === 1'b0) begin
      chk("rx_n_compl", 32'(rx_n), 32'(!rx_p));
      if (clk_out && !prev_clk) begin
        if (last_rise >= 0) chk("clk_period", cyc - last_rise, 10);
        last_rise  = cyc;
        high_start = cyc;
        if (in_word && nbits != 0) chk("word_len", nbits, 10);
        wsh = {9'b0, rx_p}; nbits = 1; in_word = 1; wstart = cyc;
      end else begin
        if (!clk_out && prev_clk && high_start >= 0) chk("clk_high", cyc - high_start, 5);
        if (in_word) begin
          wsh = {wsh[8:0], rx_p};
          nbits++;
        end
      end
      prev_clk = clk_out;
      if (in_word && nbits == 10) begin
        nbits = 0;
        handle_word(wsh);
      end
    end
  end

  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rst_rx_p", 32'(rx_p), 32'd0);
      chk("rst_rx_n", 32'(rx_n), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_clk_out", 32'(clk_out), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input logic lvl, input int limit, output int at);
    int n = 0;
    while (done !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_level", 32'(done), 32'(lvl));
    at = cyc;
  endtask

  task automatic push_seq(input logic [15:0] cfg);
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < R; r++) begin
        exp_q.push_back('{9'h0B5, cfg[7:0], cfg[15:8] | (p == 1 ? 8'h40 : 8'h00),
                          (p == 0 && r == 0)});
        exp_q.push_back('{9'h042, cfg[7:0], cfg[15:8] | (p == 1 ? 8'h40 : 8'h00), 1'b0});
      end
  endtask

  task automatic check_idle_words(input string tag);
    chk({tag, "_w0"}, 32'(wlog[0]), 32'b0011111010);
    chk({tag, "_w1"}, 32'(wlog[1]), 32'b1001000101);
    chk({tag, "_w2"}, 32'(wlog[2]), 32'b0011111010);
    chk({tag, "_w3"}, 32'(wlog[3]), 32'b1001000101);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, d_at, f_at, idle_rec;
    reset     = 1'b1;
    start     = 1'b0;
    an_config = 16'h01E0;

    // Reset and idle pattern
    apply_reset(4);
    repeat (45) @(negedge clk);
    check_idle_words("idle");

    // Long idle stretch: complement and word clock checked by the monitor
    repeat (1000) @(negedge clk);
    chk("idle_only", exp_q.size(), 0);

    // Sequence 1, with a start edge and config change while busy
    push_seq(16'h01E0);
    t0 = -1;
    @(posedge clk); #1;
    start = 1'b1;
    sc = cyc;
    repeat (150) @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    an_config = 16'hFFFF;
    wait_done(1'b1, 2000, d_at);
    chk("latency_ok", 32'(t0 - sc >= 2 && t0 - sc <= 21), 32'd1);
    chk("seq1_len", d_at - t0, SEQ_LEN);
    idle_rec = idle_sets;
    repeat (200) @(negedge clk);
    chk("seq1_done_hold", 32'(done), 32'd1);
    chk("seq1_drained", exp_q.size(), 0);
    chk("seq1_idle_after", 32'(idle_sets > idle_rec + 5), 32'd1);

    // Sequence 2: restart from done
    an_config = 16'h01E0;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    push_seq(16'h01E0);
    t0 = -1;
    #1 start = 1'b1;
    wait_done(1'b0, 40, f_at);
    wait_done(1'b1, 2000, d_at);
    chk("seq2_clear_at", f_at, t0);
    chk("seq2_len", d_at - t0, SEQ_LEN);
    repeat (60) @(negedge clk);
    chk("seq2_drained", exp_q.size(), 0);

    // Sequence 3: reset halfway through the ACK phase
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    push_seq(16'h01E0);
    #1 start = 1'b1;
    wait_done(1'b0, 40, f_at);
    repeat (480) @(negedge clk);
    apply_reset(3);
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      repeat (10) @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
    end
    check_idle_words("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
